// File: rtl/triangle_feeder.sv
// Buffers packed triangles and serialises each one as a framed 144-bit burst for the rasterizer.
// Optional culling of degenerate/back-facing triangles is enabled with `define TRI_FEEDER_CULL_EN.
module triangle_feeder #(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [143:0] TRI_IN,
  input  logic         TRI_VALID,
  output logic         TRI_READY,
  output logic         D,
  output logic         START,
  input  logic         DONE,
  output logic         BUSY,
  output logic         TIMEOUT_ERR,
  output logic [15:0]  CULL_CNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [7:0] BURST_BITS = 8'd144;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [143:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic full, empty, push, pop;
  logic [143:0] head;
  logic head_culled;

  logic [1:0] state_q, state_d;
  logic [143:0] shift_q, shift_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic d_q, d_d;
  logic start_q, start_d;
  logic terr_q, terr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = TRI_VALID && !full;
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= TRI_IN;
  end

`ifdef TRI_FEEDER_CULL_EN
  logic signed [16:0] dx21, dy31, dy21, dx31;
  logic signed [33:0] prod_a, prod_b;
  logic signed [34:0] area;
  logic cull_inc;
  logic [15:0] cull_cnt_q, cull_cnt_d;

  function automatic logic signed [16:0] coord_diff(input logic [15:0] a, input logic [15:0] b);
    return 17'($signed(a)) - 17'($signed(b));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Twice the signed area of the head triangle; non-positive means collinear or clockwise.
  always_comb begin
    dx21   = coord_diff(head[95:80],  head[143:128]);
    dy31   = coord_diff(head[31:16],  head[127:112]);
    dy21   = coord_diff(head[79:64],  head[127:112]);
    dx31   = coord_diff(head[47:32],  head[143:128]);
    prod_a = 34'(dx21) * 34'(dy31);
    prod_b = 34'(dy21) * 34'(dx31);
    area   = 35'(prod_a) - 35'(prod_b);
    head_culled = (area <= 35'sd0);
  end

  always_comb begin
    cull_inc   = pop && head_culled;
    cull_cnt_d = cull_inc ? sat_inc16(cull_cnt_q) : cull_cnt_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cull_cnt_q <= 16'd0;
    else        cull_cnt_q <= cull_cnt_d;
  end

  assign CULL_CNT = cull_cnt_q;
`else
  assign head_culled = 1'b0;
  assign CULL_CNT    = 16'd0;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    d_d        = 1'b0;
    start_d    = 1'b0;
    terr_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (!head_culled) begin
            // The first bit leaves on the pop edge; bit_cnt counts bits already driven.
            d_d       = head[143];
            start_d   = 1'b1;
            shift_d   = {head[142:0], 1'b0};
            bit_cnt_d = 8'd1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (bit_cnt_q == BURST_BITS) begin
          wait_cnt_d = 16'd0;
          state_d    = ST_WAIT;
        end else begin
          d_d       = shift_q[143];
          start_d   = 1'b1;
          shift_d   = {shift_q[142:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        // DONE takes priority over a timeout landing on the same cycle.
        if (DONE) begin
          state_d = ST_IDLE;
        end else if (TIMEOUT_EN && (({1'b0, wait_cnt_q} + 17'd1) == TIMEOUT_LIM)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      bit_cnt_q  <= 8'd0;
      wait_cnt_q <= 16'd0;
      d_q        <= 1'b0;
      start_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      d_q        <= d_d;
      start_q    <= start_d;
      terr_q     <= terr_d;
    end
  end

  assign TRI_READY   = !full;
  assign D           = d_q;
  assign START       = start_q;
  assign TIMEOUT_ERR = terr_q;
  assign BUSY        = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_triangle_feeder.sv
// Scoreboard bench for triangle_feeder: expected triangles are queued on accepted pushes and
// compared against each captured serial burst.
module tb_triangle_feeder;

  localparam int TO = 10;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [143:0] TRI_IN = '0;
  logic         TRI_VALID = 1'b0;
  logic         DONE = 1'b0;
  logic         TRI_READY, D, START, BUSY, TIMEOUT_ERR;
  logic [15:0]  CULL_CNT;

  triangle_feeder #(.FIFO_DEPTH(2), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .TRI_IN(TRI_IN), .TRI_VALID(TRI_VALID), .TRI_READY(TRI_READY),
    .D(D), .START(START), .DONE(DONE), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .CULL_CNT(CULL_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [143:0] exp_q [$];

  int           mon_cnt = 0;
  logic [143:0] mon_cap = '0;
  logic [143:0] mon_exp;

  // Capture every burst; when START falls, check its length and content against the queue head.
  always @(negedge CLK) begin
    if (!RST_N) begin
      mon_cnt = 0;
    end else if (START === 1'b1) begin
      mon_cap = {mon_cap[142:0], D};
      mon_cnt++;
    end else if (mon_cnt != 0) begin
      checks++;
      if (mon_cnt != 144) begin
        errors++;
        $display("FAIL burst_len got %0d want 144", mon_cnt);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL burst_unexpected got %h want no burst", mon_cap);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_cap !== mon_exp) begin
          errors++;
          $display("FAIL burst_data got %h want %h", mon_cap, mon_exp);
        end
      end
      mon_cnt = 0;
    end
  end

  function automatic logic [143:0] mk_tri(input logic [15:0] ofs, input logic [15:0] col);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'h0040 + ofs;
    b = 16'h0200 + ofs;
    return {a, a, col, b, a, ~col, a, b, col ^ 16'h5A5A};
  endfunction

  task automatic push_tri(input logic [143:0] t, input bit sent, output bit acc);
    @(negedge CLK);
    TRI_IN = t;
    TRI_VALID = 1'b1;
    acc = TRI_READY;
    @(posedge CLK);
    if (acc && sent) exp_q.push_back(t);
    #1 TRI_VALID = 1'b0;
  endtask

  task automatic wait_start(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK);
      if (START === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_burst(output int n);
    n = 0;
    while (START === 1'b1 && n < 300) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic pulse_done();
    @(negedge CLK);
    DONE = 1'b1;
    @(negedge CLK);
    DONE = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (START !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", START); end
    checks++; if (D !== 1'b0) begin errors++; $display("FAIL rst_d got %b want 0", D); end
    checks++; if (TRI_READY !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", TRI_READY); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL rst_terr got %b want 0", TIMEOUT_ERR); end
    checks++; if (CULL_CNT !== 16'd0) begin errors++; $display("FAIL rst_cull got %0d want 0", CULL_CNT); end
  endtask

  task automatic test_single();
    logic [143:0] t;
    bit acc;
    int n;
    t = {16'h0040, 16'h0040, 16'hF800, 16'h0200, 16'h0040, 16'h0000, 16'h0040, 16'h0200, 16'h0000};
    push_tri(t, 1'b1, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", acc); end
    @(negedge CLK);
    checks++; if (START !== 1'b0) begin errors++; $display("FAIL single_lat_early got %b want 0", START); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL single_busy_queued got %b want 1", BUSY); end
    @(negedge CLK);
    checks++; if (START !== 1'b1) begin errors++; $display("FAIL single_lat got %b want 1", START); end
    checks++; if (D !== t[143]) begin errors++; $display("FAIL single_first_bit got %b want %b", D, t[143]); end
    count_burst(n);
    checks++; if (n != 144) begin errors++; $display("FAIL single_len got %0d want 144", n); end
    checks++; if (D !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL single_wait got D=%b BUSY=%b want D=0 BUSY=1", D, BUSY); end
    repeat (3) @(negedge CLK);
    checks++; if (START !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL single_hold got START=%b TERR=%b want 0 0", START, TIMEOUT_ERR); end
    pulse_done();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    bit acc_a, acc_b, acc_c, acc_d, ok;
    int n;
    push_tri(mk_tri(16'h0100, 16'h1234), 1'b1, acc_a);
    wait_start(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_start_a got 0 want 1"); end
    push_tri(mk_tri(16'h0200, 16'(($urandom))), 1'b1, acc_b);
    push_tri(mk_tri(16'h0300, 16'(($urandom))), 1'b1, acc_c);
    push_tri(mk_tri(16'h0400, 16'h4321), 1'b1, acc_d);
    checks++; if ({acc_b, acc_c, acc_d} !== 3'b110) begin errors++; $display("FAIL b2b_accept got %b want 110", {acc_b, acc_c, acc_d}); end
    @(negedge CLK);
    checks++; if (TRI_READY !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", TRI_READY); end
    count_burst(n);
    repeat (2) @(negedge CLK);
    pulse_done();
    checks++; if (START !== 1'b0 || TRI_READY !== 1'b0) begin errors++; $display("FAIL b2b_after_done got START=%b READY=%b want 0 0", START, TRI_READY); end
    @(negedge CLK);
    checks++; if (START !== 1'b1 || TRI_READY !== 1'b1) begin errors++; $display("FAIL b2b_next got START=%b READY=%b want 1 1", START, TRI_READY); end
    count_burst(n);
    checks++; if (n != 144) begin errors++; $display("FAIL b2b_len got %0d want 144", n); end
    pulse_done();
    @(negedge CLK);
    checks++; if (START !== 1'b1) begin errors++; $display("FAIL b2b_third got %b want 1", START); end
    count_burst(n);
    pulse_done();
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", BUSY); end
  endtask

  task automatic test_done_mid_send();
    bit acc, ok;
    int n;
    push_tri(mk_tri(16'h0800, 16'hBEEF), 1'b1, acc);
    wait_start(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_start got 0 want 1"); end
    repeat (49) @(negedge CLK);
    DONE = 1'b1;
    @(negedge CLK);
    DONE = 1'b0;
    count_burst(n);
    checks++; if (n != 94) begin errors++; $display("FAIL mid_remaining got %0d want 94", n); end
    repeat (3) @(negedge CLK);
    checks++; if (BUSY !== 1'b1 || START !== 1'b0) begin errors++; $display("FAIL mid_still_wait got BUSY=%b START=%b want 1 0", BUSY, START); end
    pulse_done();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_idle got %b want 0", BUSY); end
  endtask

  task automatic test_timeout();
    bit acc, ok;
    int n, pulses, pulse_at;
    push_tri(mk_tri(16'h1000, 16'h0F0F), 1'b1, acc);
    push_tri(mk_tri(16'h1100, 16'hF0F0), 1'b1, acc);
    wait_start(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_start got 0 want 1"); end
    count_burst(n);
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= TO; i++) begin
      @(negedge CLK);
      if (TIMEOUT_ERR === 1'b1) begin
        pulses++;
        if (pulse_at == 0) pulse_at = i;
      end
    end
    checks++; if (pulses != 1 || pulse_at != TO) begin errors++; $display("FAIL to_pulse got count=%0d at=%0d want count=1 at=%0d", pulses, pulse_at, TO); end
    @(negedge CLK);
    checks++; if (START !== 1'b1 || TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL to_next got START=%b TERR=%b want 1 0", START, TIMEOUT_ERR); end
    count_burst(n);
    checks++; if (n != 144) begin errors++; $display("FAIL to_next_len got %0d want 144", n); end
    repeat (TO - 1) @(negedge CLK);
    DONE = 1'b1;
    @(negedge CLK);
    DONE = 1'b0;
    checks++; if (TIMEOUT_ERR !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL to_done_wins got TERR=%b BUSY=%b want 0 0", TIMEOUT_ERR, BUSY); end
    @(negedge CLK);
    checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL to_no_late_err got %b want 0", TIMEOUT_ERR); end
  endtask

  task automatic test_reset_mid();
    bit acc, ok, bad;
    int n;
    push_tri(mk_tri(16'h2000, 16'h1111), 1'b1, acc);
    push_tri(mk_tri(16'h2100, 16'h2222), 1'b1, acc);
    wait_start(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_start got 0 want 1"); end
    repeat (69) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++; if (START !== 1'b0 || D !== 1'b0) begin errors++; $display("FAIL rm_async got START=%b D=%b want 0 0", START, D); end
    checks++; if (BUSY !== 1'b0 || TRI_READY !== 1'b1) begin errors++; $display("FAIL rm_flush got BUSY=%b READY=%b want 0 1", BUSY, TRI_READY); end
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (START !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rm_empty_after got activity want idle"); end
    push_tri(mk_tri(16'h2200, 16'h3333), 1'b1, acc);
    wait_start(5, ok);
    count_burst(n);
    checks++; if (n != 144) begin errors++; $display("FAIL rm_recover_len got %0d want 144", n); end
    pulse_done();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rm_recover_idle got %b want 0", BUSY); end
  endtask

`ifdef TRI_FEEDER_CULL_EN
  task automatic test_cull();
    logic [143:0] collinear, reversed;
    bit acc, ok, rose;
    int n;
    collinear = {16'h0000, 16'h0000, 16'h0001, 16'h1000, 16'h1000, 16'h0002, 16'h2000, 16'h2000, 16'h0003};
    reversed  = {16'h0040, 16'h0040, 16'h0004, 16'h0040, 16'h0200, 16'h0005, 16'h0200, 16'h0040, 16'h0006};
    push_tri(collinear, 1'b0, acc);
    push_tri(reversed, 1'b0, acc);
    rose = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (START !== 1'b0) rose = 1'b1;
    end
    checks++; if (rose) begin errors++; $display("FAIL cull_no_start got 1 want 0"); end
    checks++; if (CULL_CNT !== 16'd2) begin errors++; $display("FAIL cull_cnt got %0d want 2", CULL_CNT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL cull_idle got %b want 0", BUSY); end
    push_tri(mk_tri(16'h3000, 16'h7777), 1'b1, acc);
    wait_start(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cull_valid_sent got 0 want 1"); end
    count_burst(n);
    pulse_done();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_done_mid_send();
    test_timeout();
    test_reset_mid();
`ifdef TRI_FEEDER_CULL_EN
    test_cull();
`endif
    repeat (2) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL unsent_triangles got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/triangle_feeder.md
# triangle_feeder

Parallel-to-serial front end for the triangle rasterizer. Buffers complete triangles from the host/geometry side and shifts each one out as a 144-bit serial burst on D with START framing. It then holds off until the rasterizer pulses DONE before sending the next triangle. An optional culling stage drops degenerate or back-facing triangles before they cost any rasterizer time.

## Interface
- FIFO_DEPTH, 2: triangle buffer entries; power of two, at least 2.
- TIMEOUT, 65535: maximum WAIT_DONE cycles before abort; 0 disables the timeout.
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  reset; one clock; asynchronous, active-low.
- TRI_IN  in  144  packed triangle, Q10.6 per 16-bit field: [143:128]=x1, [127:112]=y1, [111:96]=c1, [95:80]=x2, [79:64]=y2, [63:48]=c2, [47:32]=x3, [31:16]=y3, [15:0]=c3.
- TRI_VALID  in  1  TRI_IN holds a triangle.
- TRI_READY  out  1  FIFO not full.
- D  out  1  serial data to rasterizer.
- START  out  1  high on every cycle D carries a valid bit.
- DONE  in  1  one-cycle pulse from rasterizer: triangle finished.
- BUSY  out  1  state is not IDLE, or FIFO is non-empty.
- TIMEOUT_ERR  out  1  one-cycle pulse on timeout abort.
- CULL_CNT  out  16  saturating count of culled triangles.

## Operation
- Push: TRI_IN is written into the FIFO at a rising edge where TRI_VALID && TRI_READY. TRI_READY = !full, combinational from FIFO occupancy only.
- State machine: IDLE, SEND, WAIT_DONE.
- IDLE, FIFO non-empty, head not culled: pop the head into a 144-bit shift register, clear the bit counter, go to SEND.
- IDLE, head culled (macro only): pop, increment CULL_CNT, stay in IDLE.
- SEND: START=1 and D=shift[143]. The register shifts left by one each cycle. After the 144th bit, go to WAIT_DONE. Bit order is x1 MSB first through c3 LSB last. DONE is ignored while in SEND.
- WAIT_DONE: START=0, D=0.
  - DONE sampled high: go to IDLE.
  - TIMEOUT!=0 and wait counter reaches TIMEOUT: pulse TIMEOUT_ERR and go to IDLE.
  - DONE and the timeout limit in the same cycle: DONE wins, no error.
- A push and a pop on the same edge are both honoured; occupancy is unchanged.
- Wait counter is 16 bits and is cleared on entry to WAIT_DONE.
- Reset (asynchronous, at any time including mid-burst):
  - FIFO emptied, state IDLE, counters 0.
  - Outputs: D=0, START=0, TRI_READY=1, BUSY=0, TIMEOUT_ERR=0, CULL_CNT=0.
  - A partial burst is abandoned; the rasterizer must be reset alongside.

## Timing
- D and START are registered.
- First-push latency: push at edge k into an empty FIFO in IDLE → pop at edge k+1 → START high for cycles k+1 to k+145 (exactly 144 cycles) → START low from edge k+145.
- Back-to-back: after DONE is sampled at edge j, the next burst starts at edge j+1 (START rises at j+1), provided the FIFO is non-empty.
- A culled triangle occupies exactly one IDLE cycle.
- A triangle pushed at edge k is visible to the pop logic from edge k+1. There is no write-to-read bypass.

## Configuration
- TRI_FEEDER_CULL_EN defined:
  - In IDLE, the FIFO head's signed area is computed combinationally: A = (x2-x1)*(y3-y1) - (y2-y1)*(x3-x1).
  - Differences are 17-bit signed, products 34-bit signed, A is 35-bit signed.
  - Triangle is culled when A <= 0 (degenerate or wrong winding).
  - CULL_CNT saturates at 16'hFFFF.
- TRI_FEEDER_CULL_EN undefined:
  - No multipliers are synthesised and every triangle is sent.
  - CULL_CNT is tied to 0.

## Test plan
- Reset then single push TRI_IN = {x1=16'h0040, y1=16'h0040, c1=16'hF800, x2=16'h0200, y2=16'h0040, c2=0, x3=16'h0040, y3=16'h0200, c3=0} → START high for exactly 144 cycles; captured D stream equals TRI_IN MSB first; then START=0 until DONE.
- Push 3 triangles back-to-back with FIFO_DEPTH=2 and DONE withheld → 2 accepted, TRI_READY=0 on third; DONE pulse → second burst begins the next cycle, TRI_READY returns to 1.
- DONE pulsed mid-SEND (bit 50) → ignored, burst completes 144 bits, state stays WAIT_DONE until a later DONE.
- TIMEOUT=10, no DONE → TIMEOUT_ERR one-cycle pulse 10 cycles after the last bit; the next queued triangle is sent immediately after. A variant with DONE on the limit cycle → no error.
- Assert RST_N low at bit 70 → START and D drop to 0 asynchronously, BUSY=0, FIFO empty after release.
- With TRI_FEEDER_CULL_EN: push a collinear triangle (0,0), (64,64), (128,128) and a reversed-winding triangle → both culled, CULL_CNT=2, START never rises; a following valid triangle is sent normally.
